alarm_bank: RTL
===============

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm slots (2..16).
REQ-002 Parameter RING_SEC, default 30, ring duration in seconds (1..255).
REQ-003 Parameter SNOOZE_SEC, default 300, snooze delay in seconds (1..65535); used only when ALARM_SNOOZE_EN is defined.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 clk1sec  input  1  one-clk-wide pulse, once per second.
REQ-007 sw_in  input  4  key command: 1000 next field, 0100 previous field, 0010 increment, 0001 decrement; any other value is no-op.
REQ-008 hour, minute, second  input  8 each  current time, binary.
REQ-009 cursor  output  3  edit field: 0 slot, 1 hour, 2 minute, 3 second, 4 enable.
REQ-010 slot  output  SW=max(1,$clog2(NUM_ALARMS))  slot being edited.
REQ-011 edit_time  output  24  {hour,minute,second} of the edited slot, binary.
REQ-012 en_mask  output  NUM_ALARMS  per-slot enable bits.
REQ-013 ring  output  1  alarm sounding.
REQ-014 ring_slot  output  SW  slot that caused the current ring.

Function
REQ-015 Each slot SHALL hold 8-bit hour (0..23), minute (0..59), second (0..59) and one enable bit.
REQ-016 1000 SHALL advance cursor, saturating at 4; 0100 SHALL retreat, saturating at 0.
REQ-017 0010/0001 SHALL increment/decrement the cursor field of the selected slot by 1 with wrap: slot 0..NUM_ALARMS-1, hour 0..23, minute 0..59, second 0..59 (e.g. 23+1->0, 0-1->59 minute); on cursor 4 either key SHALL toggle enable.
REQ-018 Edits SHALL take effect on the clk edge after the key cycle; edit_time, slot, cursor, en_mask SHALL be registered, reflecting state one clk after change.
REQ-019 FSM states IDLE, RING, SNOOZE (SNOOZE only with macro).
REQ-020 IDLE->RING on a clk1sec cycle when an enabled slot equals {hour,minute,second} sampled that cycle; ring_slot = lowest matching index; ring asserts next clk.
REQ-021 In RING a counter SHALL count clk1sec pulses; at RING_SEC pulses -> IDLE, ring deasserts.
REQ-022 In RING any valid sw_in command SHALL dismiss (-> IDLE) and SHALL NOT edit cursor or slot data.
REQ-023 Matches occurring while in RING or SNOOZE SHALL be ignored (not queued).
REQ-024 An edit that disables or changes the ringing slot SHALL NOT stop the ring.
REQ-025 Invalid stored values are impossible by construction; increment never exceeds field maximum.

Reset
REQ-026 On rst high, immediately: all slot fields 0, en_mask 0, cursor 0, slot 0, state IDLE, ring 0, ring_slot 0, counters 0, edit_time 0.
REQ-027 Reset mid-ring or mid-snooze SHALL abort with no pending re-ring after release.

Configuration
REQ-028 Macro ALARM_SNOOZE_EN: when defined, in RING 0001 SHALL -> SNOOZE (ring 0), other valid keys dismiss; after SNOOZE_SEC clk1sec pulses -> RING with same ring_slot and fresh RING_SEC count; any valid key in SNOOZE cancels -> IDLE without edit.
REQ-029 When not defined, SNOOZE state and its counter SHALL not exist and 0001 in RING dismisses like any key.

Verification
REQ-030 Reset, cursor=1, 0001 -> slot0 hour 23; 0010 -> 0.
REQ-031 Slot 2 = 07:30:00 enabled, slot 1 same time enabled, time 07:30:00 with clk1sec -> ring=1 next clk, ring_slot=1.
REQ-032 Ring with no keys, RING_SEC=3 -> ring drops after third subsequent clk1sec pulse.
REQ-033 Ring, sw_in=1000 -> ring=0, cursor unchanged.
REQ-034 ALARM_SNOOZE_EN, SNOOZE_SEC=2: ring, 0001 -> ring=0; after 2 clk1sec -> ring=1, same ring_slot.
REQ-035 rst asserted asynchronously during RING -> ring=0 without clk edge; en_mask=0 after release.

Source files
------------

// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot alarm clock with key editor and ring FSM.
// Optional snooze state enabled by defining ALARM_SNOOZE_EN.
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 300,
  localparam int SW = ($clog2(NUM_ALARMS) > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk1sec,
  input  logic [3:0]            sw_in,
  input  logic [7:0]            hour,
  input  logic [7:0]            minute,
  input  logic [7:0]            second,
  output logic [2:0]            cursor,
  output logic [SW-1:0]         slot,
  output logic [23:0]           edit_time,
  output logic [NUM_ALARMS-1:0] en_mask,
  output logic                  ring,
  output logic [SW-1:0]         ring_slot
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;
  localparam logic [15:0] SN_LAST = 16'(SNOOZE_SEC - 1);
  logic [15:0] snz_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_RING} state_t;
`endif

  localparam logic [7:0] RS_LAST = 8'(RING_SEC - 1);
  localparam logic [7:0] SL_MAX  = 8'(NUM_ALARMS - 1);

  state_t state;
  logic [7:0] ring_cnt;

  logic [7:0] hr [NUM_ALARMS];
  logic [7:0] mn [NUM_ALARMS];
  logic [7:0] sc [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en;

  logic k_next, k_prev, k_inc, k_dec, k_any;
  logic hit;
  logic [SW-1:0] hit_idx;

  assign k_next  = (sw_in == 4'b1000);
  assign k_prev  = (sw_in == 4'b0100);
  assign k_inc   = (sw_in == 4'b0010);
  assign k_dec   = (sw_in == 4'b0001);
  assign k_any   = k_next | k_prev | k_inc | k_dec;
  assign en_mask = en;

  // Wrap-around step of a field bounded by [0, mx].
  function automatic logic [7:0] step8(
    input logic [7:0] v,
    input logic [7:0] mx,
    input logic       up
  );
    if (up) return (v == mx) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0) ? mx : v - 8'd1;
  endfunction

  // Lowest-index enabled slot matching the current time.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (en[i] && hr[i] == hour && mn[i] == minute &&
          sc[i] == second) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // Key-driven editor; keys only edit while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hr[i] <= '0;
        mn[i] <= '0;
        sc[i] <= '0;
      end
      en        <= '0;
      cursor    <= '0;
      slot      <= '0;
      edit_time <= '0;
    end else begin
      edit_time <= {hr[slot], mn[slot], sc[slot]};
      if (state == S_IDLE) begin
        unique case (1'b1)
          k_next: if (cursor != 3'd4) cursor <= cursor + 3'd1;
          k_prev: if (cursor != 3'd0) cursor <= cursor - 3'd1;
          k_inc, k_dec: begin
            case (cursor)
              3'd0: slot <= SW'(step8(8'(slot), SL_MAX, k_inc));
              3'd1: hr[slot] <= step8(hr[slot], 8'd23, k_inc);
              3'd2: mn[slot] <= step8(mn[slot], 8'd59, k_inc);
              3'd3: sc[slot] <= step8(sc[slot], 8'd59, k_inc);
              3'd4: en[slot] <= ~en[slot];
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Ring FSM with registered ring output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ring      <= 1'b0;
      ring_slot <= '0;
      ring_cnt  <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (clk1sec && hit) begin
            state     <= S_RING;
            ring      <= 1'b1;
            ring_slot <= hit_idx;
            ring_cnt  <= '0;
          end
        end
        S_RING: begin
`ifdef ALARM_SNOOZE_EN
          if (k_dec) begin
            state    <= S_SNOOZE;
            ring     <= 1'b0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
          end else
`endif
          if (k_any) begin
            state    <= S_IDLE;
            ring     <= 1'b0;
            ring_cnt <= '0;
          end else if (clk1sec) begin
            if (ring_cnt == RS_LAST) begin
              state    <= S_IDLE;
              ring     <= 1'b0;
              ring_cnt <= '0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (k_any) begin
            state   <= S_IDLE;
            snz_cnt <= '0;
          end else if (clk1sec) begin
            if (snz_cnt == SN_LAST) begin
              state    <= S_RING;
              ring     <= 1'b1;
              ring_cnt <= '0;
              snz_cnt  <= '0;
            end else begin
              snz_cnt <= snz_cnt + 16'd1;
            end
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          ring  <= 1'b0;
        end
      endcase
    end
  end

endmodule
